prog_loader: RTL and testbench
==============================

# prog_loader

Program loader for the npl_cpu instruction memory. Accepts a framed byte stream over a valid/ready interface, packs the bytes big-endian into 32-bit instruction words and writes them to consecutive memory addresses starting at 0. It holds the CPU in reset while loading. It releases the CPU only after the whole frame is received and its checksum matches. The block sits between the host/debug byte link and the instruction memory write port. It is the writer for the CPU's instruction fetch.

## Interface
- WIDTH, 32, instruction/data word width (4 bytes per word, fixed)
- ADDRSIZE, 12, memory address width
- MAXWORDS, 1<<ADDRSIZE, maximum legal word count in a frame
- clk  input  1  clock
- reset  input  1  reset, synchronous, active-low
- in_valid  input  1  byte available on in_data
- in_data  input  8  stream byte
- in_ready  output  1  loader accepts byte; transfer = in_valid && in_ready at rising edge
- start  input  1  single-cycle pulse; restarts loading from DONE or ERR
- mem_we  output  1  one-cycle memory write strobe
- mem_addr  output  ADDRSIZE  write address
- mem_wdata  output  WIDTH  write data
- cpu_rst_n  output  1  CPU reset, low = held
- done  output  1  frame loaded and checksum OK
- err  output  1  frame rejected

## Operation
- Frame layout: CNT_HI, CNT_LO (16-bit word count N), then 4·N data bytes, most significant byte first per word, then CSUM.
- CSUM is the XOR of every preceding byte in the frame, including both count bytes.
- States and transitions:
  - HDR_HI: accept CNT_HI → HDR_LO.
  - HDR_LO: accept CNT_LO. If N == 0 or N > MAXWORDS → ERR, else → DATA.
  - DATA: shift each byte into a 32-bit packer. On the 4th byte of a word, issue the write and increment the word index. After word N-1 → CSUM.
  - CSUM: accept the byte. If it equals the running XOR → DONE, else → ERR.
  - DONE: done=1, cpu_rst_n=1, in_ready=0. A start pulse → HDR_HI with cpu_rst_n=0 and done=0 on the next cycle.
  - ERR: err=1, cpu_rst_n=0, in_ready=0. A start pulse → HDR_HI with err=0.
- start is ignored in HDR_HI, HDR_LO, DATA and CSUM.
- Word index starts at 0 at every entry to HDR_HI. With N = MAXWORDS the last write goes to address MAXWORDS-1; the index never wraps into a second pass.
- Words written before a checksum failure stay in memory. The CPU remains in reset.
- Memory writes have no backpressure; the memory completes any write in a single cycle.

## Timing
- Reset (reset=0 at the edge) forces, on that edge:
  - outputs: in_ready=0, mem_we=0, mem_addr=0, mem_wdata=0, done=0, err=0, cpu_rst_n=0
  - internal: state HDR_HI, XOR accumulator and word index cleared
- in_ready is registered. It is 1 from the first cycle after reset is released while the state is HDR_HI, HDR_LO, DATA or CSUM.
- mem_we pulses for exactly one cycle, the cycle after the 4th-byte handshake of a word. mem_addr and mem_wdata are valid in that same cycle.
- in_ready stays 1 during the write, so back-to-back bytes sustain 1 byte per cycle.
- The done/err and cpu_rst_n updates appear the cycle after the CSUM or CNT_LO handshake that decides them.
- Reset asserted mid-frame aborts immediately. Partial words are discarded, and the next frame starts at address 0.
- Bubbles on in_valid at any point leave all state unchanged.

## Structure
- Package npl_cpu_pkg holds WIDTH, ADDRSIZE, MAXWORDS and the state enum (HDR_HI, HDR_LO, DATA, CSUM, DONE, ERR).
- One sub-module is natural: byte_packer. It takes a 4-byte shift register plus a 2-bit byte counter and produces word_valid/word.
- The FSM, XOR accumulator and address counter stay in prog_loader.

## Test plan
- Two-word frame: bytes 00 02 20 00 00 05 90 00 00 00 B7 → writes MEM[0]=0x20000005 and MEM[1]=0x90000000; one cycle after B7, done=1 and cpu_rst_n=1.
- Same frame with CSUM=0x00 → both writes occur, then err=1, cpu_rst_n=0, in_ready=0.
- Count errors: CNT 00 00 → err=1 after the 2nd byte with no mem_we; CNT 10 01 (N=4097) → err=1.
- Random in_valid bubbles on the two-word frame → identical writes and done; mem_we is never wider than one cycle.
- reset=0 after 6 bytes of a frame → all outputs return to reset values; a following valid frame writes starting at address 0.
- start in DONE, then a full 4096-word frame → cpu_rst_n=0 the next cycle, the last write goes to mem_addr 0xFFF, done=1 with the correct CSUM.

Source files
------------

// File: rtl/npl_cpu_pkg.sv
// Shared constants and the loader state encoding for the npl_cpu program loader.
package npl_cpu_pkg;

    localparam int unsigned WIDTH    = 32;
    localparam int unsigned ADDRSIZE = 12;
    localparam int unsigned MAXWORDS = 1 << ADDRSIZE;

    typedef enum logic [2:0] {
        HDR_HI,
        HDR_LO,
        DATA,
        CSUM,
        DONE,
        ERR
    } state_t;

endpackage

// File: rtl/byte_packer.sv
// Packs a byte stream big-endian into WIDTH-bit words.
// Only the first three bytes of a word are stored. The fourth byte is
// combined combinationally, so the word is available in its handshake cycle.
module byte_packer
    import npl_cpu_pkg::*;
(
    input  logic             clk,
    input  logic             reset,
    input  logic             clear,
    input  logic             byte_valid,
    input  logic [7:0]       byte_data,
    output logic             word_valid,
    output logic [WIDTH-1:0] word
);

    logic [WIDTH-9:0] shreg;
    logic [1:0]       cnt;

    // Shift accepted bytes in MSB-first and count byte position within the word.
    always_ff @(posedge clk) begin
        if (!reset || clear) begin
            shreg <= '0;
            cnt   <= '0;
        end else if (byte_valid) begin
            shreg <= {shreg[WIDTH-17:0], byte_data};
            cnt   <= cnt + 2'd1;
        end
    end

    assign word_valid = byte_valid && (cnt == 2'd3);
    assign word       = {shreg, byte_data};

endmodule

// File: rtl/prog_loader.sv
// Program loader: receives a framed byte stream and writes packed instruction
// words to memory from address 0. The CPU is held in reset until a frame with
// a matching XOR checksum has been fully received.
module prog_loader
    import npl_cpu_pkg::*;
(
    input  logic                clk,
    input  logic                reset,
    input  logic                in_valid,
    input  logic [7:0]          in_data,
    output logic                in_ready,
    input  logic                start,
    output logic                mem_we,
    output logic [ADDRSIZE-1:0] mem_addr,
    output logic [WIDTH-1:0]    mem_wdata,
    output logic                cpu_rst_n,
    output logic                done,
    output logic                err
);

    state_t              state;
    logic [7:0]          csum;
    logic [15:0]         count;
    logic [ADDRSIZE-1:0] widx;

    logic                fire;
    logic                data_fire;
    logic                restart;
    logic                word_valid;
    logic [WIDTH-1:0]    word;
    logic [15:0]         hdr_n;
    logic                last_word;

    assign fire      = in_valid && in_ready;
    assign data_fire = fire && (state == DATA);
    assign restart   = start && ((state == DONE) || (state == ERR));
    assign hdr_n     = {count[15:8], in_data};
    assign last_word = (16'(widx) == (count - 16'd1));

    byte_packer u_packer (
        .clk        (clk),
        .reset      (reset),
        .clear      (restart),
        .byte_valid (data_fire),
        .byte_data  (in_data),
        .word_valid (word_valid),
        .word       (word)
    );

    // Frame FSM with the checksum accumulator, word index and registered outputs.
    always_ff @(posedge clk) begin
        if (!reset) begin
            state     <= HDR_HI;
            csum      <= '0;
            count     <= '0;
            widx      <= '0;
            in_ready  <= 1'b0;
            mem_we    <= 1'b0;
            mem_addr  <= '0;
            mem_wdata <= '0;
            cpu_rst_n <= 1'b0;
            done      <= 1'b0;
            err       <= 1'b0;
        end else begin
            mem_we <= 1'b0;
            unique case (state)
                HDR_HI: begin
                    in_ready <= 1'b1;
                    if (fire) begin
                        csum        <= csum ^ in_data;
                        count[15:8] <= in_data;
                        state       <= HDR_LO;
                    end
                end
                HDR_LO: begin
                    if (fire) begin
                        csum       <= csum ^ in_data;
                        count[7:0] <= in_data;
                        if ((hdr_n == 16'd0) || (hdr_n > 16'(MAXWORDS))) begin
                            state    <= ERR;
                            err      <= 1'b1;
                            in_ready <= 1'b0;
                        end else begin
                            state <= DATA;
                        end
                    end
                end
                DATA: begin
                    if (fire) begin
                        csum <= csum ^ in_data;
                    end
                    if (word_valid) begin
                        mem_we    <= 1'b1;
                        mem_addr  <= widx;
                        mem_wdata <= word;
                        widx      <= widx + ADDRSIZE'(1);
                        if (last_word) begin
                            state <= CSUM;
                        end
                    end
                end
                CSUM: begin
                    if (fire) begin
                        in_ready <= 1'b0;
                        if (in_data == csum) begin
                            state     <= DONE;
                            done      <= 1'b1;
                            cpu_rst_n <= 1'b1;
                        end else begin
                            state <= ERR;
                            err   <= 1'b1;
                        end
                    end
                end
                DONE, ERR: begin
                    in_ready <= 1'b0;
                    if (restart) begin
                        state     <= HDR_HI;
                        in_ready  <= 1'b1;
                        csum      <= '0;
                        count     <= '0;
                        widx      <= '0;
                        done      <= 1'b0;
                        err       <= 1'b0;
                        cpu_rst_n <= 1'b0;
                    end
                end
                default: state <= HDR_HI;
            endcase
        end
    end

endmodule

// File: tb/tb_prog_loader.sv
// Directed bench for prog_loader: frames, checksum and count errors,
// in_valid bubbles, mid-frame reset and a full-size frame.
module tb_prog_loader;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        in_valid = 1'b0;
    logic [7:0]  in_data = 8'h00;
    logic        in_ready;
    logic        start = 1'b0;
    logic        mem_we;
    logic [11:0] mem_addr;
    logic [31:0] mem_wdata;
    logic        cpu_rst_n;
    logic        done;
    logic        err;

    int vectors = 0;
    int miscompares = 0;

    // Write log filled from the memory port.
    logic [11:0] wr_addr [0:8191];
    logic [31:0] wr_data [0:8191];
    int          nwr = 0;
    logic        prev_we = 1'b0;
    logic        wide_we = 1'b0;

    logic [7:0]  frame_ok [0:10];
    int          base;
    logic [7:0]  xsum;
    logic [31:0] w;

    prog_loader dut (
        .clk       (clk),
        .reset     (reset),
        .in_valid  (in_valid),
        .in_data   (in_data),
        .in_ready  (in_ready),
        .start     (start),
        .mem_we    (mem_we),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .cpu_rst_n (cpu_rst_n),
        .done      (done),
        .err       (err)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (mem_we) begin
            wr_addr[nwr] = mem_addr;
            wr_data[nwr] = mem_wdata;
            nwr = nwr + 1;
            if (prev_we) wide_we = 1'b1;
        end
        prev_we = mem_we;
    end

    task automatic tick();
        @(negedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic send_byte(input logic [7:0] b);
        int t = 0;
        in_valid = 1'b1;
        in_data  = b;
        while (in_ready !== 1'b1 && t < 50) begin
            tick();
            t++;
        end
        if (t >= 50) begin
            vectors++;
            miscompares++;
            $display("FAIL ready_timeout: in_ready stayed %b, required 1", in_ready);
        end
        tick();
        in_valid = 1'b0;
    endtask

    task automatic send_frame(input logic [7:0] last, input bit bubbles);
        for (int i = 0; i < 10; i++) begin
            if (bubbles) repeat ($urandom_range(0, 3)) tick();
            send_byte(frame_ok[i]);
        end
        if (bubbles) repeat ($urandom_range(0, 3)) tick();
        send_byte(last);
    endtask

    task automatic pulse_start();
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_in_ready"}, 32'(in_ready), 32'd0);
        check({tag, "_mem_we"}, 32'(mem_we), 32'd0);
        check({tag, "_mem_addr"}, 32'(mem_addr), 32'd0);
        check({tag, "_mem_wdata"}, mem_wdata, 32'd0);
        check({tag, "_done"}, 32'(done), 32'd0);
        check({tag, "_err"}, 32'(err), 32'd0);
        check({tag, "_cpu_rst_n"}, 32'(cpu_rst_n), 32'd0);
    endtask

    initial begin
        frame_ok = '{8'h00, 8'h02, 8'h20, 8'h00, 8'h00, 8'h05,
                     8'h90, 8'h00, 8'h00, 8'h00, 8'hB7};

        // Reset state
        tick();
        tick();
        check_reset_outputs("rst");
        reset = 1'b1;
        tick();
        check("rst_ready_after", 32'(in_ready), 32'd1);

        // Two-word frame, good checksum
        base = nwr;
        send_frame(8'hB7, 1'b0);
        check("ok_done", 32'(done), 32'd1);
        check("ok_cpu_rst_n", 32'(cpu_rst_n), 32'd1);
        check("ok_err", 32'(err), 32'd0);
        check("ok_in_ready", 32'(in_ready), 32'd0);
        check("ok_nwr", 32'(nwr - base), 32'd2);
        check("ok_a0", 32'(wr_addr[base]), 32'd0);
        check("ok_d0", wr_data[base], 32'h2000_0005);
        check("ok_a1", 32'(wr_addr[base+1]), 32'd1);
        check("ok_d1", wr_data[base+1], 32'h9000_0000);

        // Restart, same frame with a bad checksum
        pulse_start();
        check("rs_done", 32'(done), 32'd0);
        check("rs_cpu_rst_n", 32'(cpu_rst_n), 32'd0);
        check("rs_in_ready", 32'(in_ready), 32'd1);
        base = nwr;
        send_frame(8'h00, 1'b0);
        check("bad_err", 32'(err), 32'd1);
        check("bad_done", 32'(done), 32'd0);
        check("bad_cpu_rst_n", 32'(cpu_rst_n), 32'd0);
        check("bad_in_ready", 32'(in_ready), 32'd0);
        check("bad_nwr", 32'(nwr - base), 32'd2);
        check("bad_d1", wr_data[base+1], 32'h9000_0000);

        // Zero word count
        pulse_start();
        check("z_err_cleared", 32'(err), 32'd0);
        base = nwr;
        send_byte(8'h00);
        send_byte(8'h00);
        check("z_err", 32'(err), 32'd1);
        check("z_in_ready", 32'(in_ready), 32'd0);
        tick();
        check("z_nwr", 32'(nwr - base), 32'd0);

        // Word count one above the maximum
        pulse_start();
        send_byte(8'h10);
        send_byte(8'h01);
        check("big_err", 32'(err), 32'd1);
        check("big_cpu_rst_n", 32'(cpu_rst_n), 32'd0);

        // Good frame with random in_valid bubbles
        pulse_start();
        base = nwr;
        send_frame(8'hB7, 1'b1);
        check("bub_done", 32'(done), 32'd1);
        check("bub_nwr", 32'(nwr - base), 32'd2);
        check("bub_a0", 32'(wr_addr[base]), 32'd0);
        check("bub_d0", wr_data[base], 32'h2000_0005);
        check("bub_a1", 32'(wr_addr[base+1]), 32'd1);
        check("bub_d1", wr_data[base+1], 32'h9000_0000);

        // Reset after six bytes, then a fresh one-word frame
        pulse_start();
        for (int i = 0; i < 6; i++) send_byte(frame_ok[i]);
        reset = 1'b0;
        tick();
        check_reset_outputs("mid");
        reset = 1'b1;
        tick();
        base = nwr;
        send_byte(8'h00);
        send_byte(8'h01);
        send_byte(8'hDE);
        send_byte(8'hAD);
        send_byte(8'hBE);
        send_byte(8'hEF);
        send_byte(8'h23);
        check("mid_done", 32'(done), 32'd1);
        check("mid_nwr", 32'(nwr - base), 32'd1);
        check("mid_a0", 32'(wr_addr[base]), 32'd0);
        check("mid_d0", wr_data[base], 32'hDEAD_BEEF);

        // Restart from DONE, then a full-size frame
        pulse_start();
        check("full_cpu_rst_n", 32'(cpu_rst_n), 32'd0);
        check("full_done_cleared", 32'(done), 32'd0);
        base = nwr;
        xsum = 8'h10 ^ 8'h00;
        send_byte(8'h10);
        send_byte(8'h00);
        for (int i = 0; i < 4096; i++) begin
            w = {16'(i), ~16'(i)};
            for (int k = 3; k >= 0; k--) begin
                xsum = xsum ^ w[k*8 +: 8];
                send_byte(w[k*8 +: 8]);
            end
        end
        send_byte(xsum);
        check("full_done", 32'(done), 32'd1);
        check("full_cpu_rst_n_up", 32'(cpu_rst_n), 32'd1);
        check("full_nwr", 32'(nwr - base), 32'd4096);
        check("full_first_a", 32'(wr_addr[base]), 32'd0);
        check("full_first_d", wr_data[base], 32'h0000_FFFF);
        check("full_last_a", 32'(wr_addr[base+4095]), 32'hFFF);
        check("full_last_d", wr_data[base+4095], 32'h0FFF_F000);

        check("mem_we_single", 32'(wide_we), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
